// File: rtl/adc_decimator_if.sv
// adc_decimator_if -- bundles the sample input, control and result handshake
// signals of adc_decimator.
//   master : drives en/data/data_valid/dec/shift/ready/clr_ovf, observes results
//   slave  : the decimator side (consumes inputs, produces data_o/valid_o/overflow_o)
interface adc_decimator_if #(
  parameter int IW      = 12,
  parameter int OW      = 16,
  parameter int NCH     = 2,
  parameter int DEC_MAX = 20
);
  localparam int AW = IW + $clog2(DEC_MAX);
  localparam int DW = $clog2(DEC_MAX + 1);
  localparam int SW = $clog2(AW);

  logic              en_i;
  logic [NCH*IW-1:0] data_i;
  logic              data_valid_i;
  logic [DW-1:0]     dec_i;
  logic [SW-1:0]     shift_i;
  logic              ready_i;
  logic              clr_ovf_i;
  logic [NCH*OW-1:0] data_o;
  logic              valid_o;
  logic              overflow_o;

  modport master (
    output en_i, data_i, data_valid_i, dec_i, shift_i, ready_i, clr_ovf_i,
    input  data_o, valid_o, overflow_o
  );

  modport slave (
    input  en_i, data_i, data_valid_i, dec_i, shift_i, ready_i, clr_ovf_i,
    output data_o, valid_o, overflow_o
  );
endinterface

// File: rtl/adc_decimator.sv
// adc_decimator -- multi-channel integrate-and-dump decimator.
// Sums D valid samples per channel (D chosen at frame start from dec_i),
// arithmetically shifts the frame sum, saturates it to OW bits and offers it
// on a valid/ready output that drops (and flags) results arriving while the
// previous one is still unaccepted.
//   clk_i  : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : adc_decimator_if slave (samples, controls, result handshake)
module adc_decimator #(
  parameter int IW      = 12,
  parameter int OW      = 16,
  parameter int NCH     = 2,
  parameter int DEC_MAX = 20
) (
  input logic            clk_i,
  input logic            rst_n,
  adc_decimator_if.slave bus
);
  localparam int AW = IW + $clog2(DEC_MAX);
  localparam int DW = $clog2(DEC_MAX + 1);
  localparam int XW = ((AW > OW) ? AW : OW) + 1;
  // Output range limits, held one bit wider than both AW and OW so the same
  // comparison works whether or not the sum can exceed the output width.
  localparam logic signed [XW-1:0] OMAX = {{(XW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [XW-1:0] OMIN = {{(XW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  function automatic logic [OW-1:0] saturate(input logic signed [AW-1:0] v);
    logic signed [XW-1:0] vx;
    vx = XW'(v);
    if (vx > OMAX) begin
      saturate = OMAX[OW-1:0];
    end else if (vx < OMIN) begin
      saturate = OMIN[OW-1:0];
    end else begin
      saturate = vx[OW-1:0];
    end
  endfunction

  function automatic logic [DW-1:0] clamp_dec(input logic [DW-1:0] d);
    if (d == '0) begin
      clamp_dec = DW'(1);
    end else if (d > DW'(DEC_MAX)) begin
      clamp_dec = DW'(DEC_MAX);
    end else begin
      clamp_dec = d;
    end
  endfunction

  logic [NCH*IW-1:0]    data_r;
  logic                 dvalid_r;
  logic [DW-1:0]        cnt_r;
  logic [DW-1:0]        dec_r;
  logic signed [AW-1:0] acc_r [NCH];
  logic [NCH*OW-1:0]    res_r;
  logic                 res_vld_r;
  logic [NCH*OW-1:0]    data_out_r;
  logic                 valid_r;
  logic                 ovf_r;

  logic                 first_s;
  logic                 last_s;
  logic [DW-1:0]        dec_cur_s;
  logic signed [AW-1:0] smp_s     [NCH];
  logic signed [AW-1:0] acc_nxt_s [NCH];
  logic [NCH*OW-1:0]    res_nxt_s;
  logic                 blocked_s;

  // Frame bookkeeping and per-channel running sums for the registered sample.
  always_comb begin
    first_s = (cnt_r == '0);
    // The frame length is only taken from dec_i on the first sample of a frame.
    if (first_s) begin
      dec_cur_s = clamp_dec(bus.dec_i);
    end else begin
      dec_cur_s = dec_r;
    end
    last_s    = (cnt_r == (dec_cur_s - DW'(1)));
    res_nxt_s = '0;
    for (int c = 0; c < NCH; c++) begin
      smp_s[c] = AW'(signed'(data_r[c*IW +: IW]));
      if (first_s) begin
        acc_nxt_s[c] = smp_s[c];
      end else begin
        acc_nxt_s[c] = acc_r[c] + smp_s[c];
      end
      res_nxt_s[c*OW +: OW] = saturate(acc_nxt_s[c] >>> bus.shift_i);
    end
  end

  // Input capture: everything downstream works on these registered copies.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      data_r   <= '0;
      dvalid_r <= 1'b0;
    end else begin
      data_r   <= bus.data_i;
      dvalid_r <= bus.data_valid_i;
    end
  end

  // Sample counter, accumulators and the finished-frame result register.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r     <= '0;
      dec_r     <= DW'(1);
      res_r     <= '0;
      res_vld_r <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        acc_r[c] <= '0;
      end
    end else if (!bus.en_i) begin
      cnt_r     <= '0;
      res_vld_r <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        acc_r[c] <= '0;
      end
    end else if (dvalid_r) begin
      if (first_s) begin
        dec_r <= dec_cur_s;
      end
      for (int c = 0; c < NCH; c++) begin
        acc_r[c] <= acc_nxt_s[c];
      end
      if (last_s) begin
        cnt_r     <= '0;
        res_r     <= res_nxt_s;
        res_vld_r <= 1'b1;
      end else begin
        cnt_r     <= cnt_r + DW'(1);
        res_vld_r <= 1'b0;
      end
    end else begin
      res_vld_r <= 1'b0;
    end
  end

  // A new result is blocked only when the held one is neither absent nor leaving.
  assign blocked_s = res_vld_r && valid_r && !bus.ready_i;

  // Output holding register, handshake and sticky overflow flag.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      data_out_r <= '0;
      valid_r    <= 1'b0;
      ovf_r      <= 1'b0;
    end else begin
      if (res_vld_r && !blocked_s) begin
        data_out_r <= res_r;
        valid_r    <= 1'b1;
      end else if (!res_vld_r && bus.ready_i) begin
        valid_r    <= 1'b0;
      end
      // Setting has priority over a simultaneous clear.
      if (blocked_s) begin
        ovf_r <= 1'b1;
      end else if (bus.clr_ovf_i) begin
        ovf_r <= 1'b0;
      end
    end
  end

  assign bus.data_o     = data_out_r;
  assign bus.valid_o    = valid_r;
  assign bus.overflow_o = ovf_r;
endmodule
